// File: rtl/t_ram_burst_ctrl.sv
// Burst sequencer in front of the single-port scratch RAM: turns one burst
// command into RAM write strobes or credit-limited reads returned via a skid FIFO.
module t_ram_burst_ctrl #(
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          sys_rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_addr,
    input  logic [AW-1:0] cmd_len,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic          busy,
    output logic          done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WR    = 2'd1;
    localparam logic [1:0] S_RD    = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;
    localparam logic [AW-1:0] A_ONE = AW'(1);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] cur_addr_q, cur_addr_d;
    logic [AW-1:0] remaining_q, remaining_d;
    logic          inflight_q, inflight_d;
    logic          done_q, done_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [1:0]    wp_q, wp_d;
    logic [1:0]    rp_q, rp_d;
    logic [DW-1:0] mem_q [4];

    logic          wr_strobe;
    logic          rd_issue;
    logic          push;
    logic          pop;
    logic [2:0]    occ;

    assign push = inflight_q;
    assign pop  = rd_valid && rd_ready;
    // Words buffered plus the one still coming back from the RAM.
    assign occ  = cnt_q + {2'b00, inflight_q};

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        wr_strobe   = 1'b0;
        rd_issue    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    cur_addr_d  = cmd_addr;
                    remaining_d = cmd_len;
                    state_d     = cmd_we ? S_WR : S_RD;
                end
            end
            S_WR: begin
                if (wr_valid) begin
                    wr_strobe   = 1'b1;
                    cur_addr_d  = cur_addr_q + A_ONE;
                    remaining_d = remaining_q - A_ONE;
                    if (remaining_q == '0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_RD: begin
                if (occ < 3'd4) begin
                    rd_issue    = 1'b1;
                    cur_addr_d  = cur_addr_q + A_ONE;
                    remaining_d = remaining_q - A_ONE;
                    if (remaining_q == '0) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!inflight_q && cnt_q == 3'd0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        inflight_d = rd_issue;
        wp_d       = push ? wp_q + 2'd1 : wp_q;
        rp_d       = pop ? rp_q + 2'd1 : rp_q;
        cnt_d      = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 3'd1;
            2'b01:   cnt_d = cnt_q - 3'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= 3'd0;
            wp_q        <= 2'd0;
            rp_q        <= 2'd0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
            done_q      <= done_d;
            cnt_q       <= cnt_d;
            wp_q        <= wp_d;
            rp_q        <= rp_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by cnt_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wp_q] <= ram_dout;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign wr_ready  = (state_q == S_WR);
    assign done      = done_q;
    assign rd_valid  = (cnt_q != 3'd0);
    assign rd_data   = mem_q[rp_q];
    assign ram_en    = wr_strobe || rd_issue;
    assign ram_we    = wr_strobe;
    assign ram_addr  = ram_en ? cur_addr_q : '0;
    assign ram_din   = wr_strobe ? wr_data : '0;

endmodule

// File: tb/tb_t_ram_burst_ctrl.sv
// Randomized scoreboard bench for t_ram_burst_ctrl with a behavioural RAM
// and a word-level memory model producing expected strobes and read data.
module tb_t_ram_burst_ctrl;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          sys_rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [AW-1:0] cmd_len;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic          busy;
    logic          done;

    t_ram_burst_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .sys_rst(sys_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM with registered read data, zero when not reading.
    logic [DW-1:0] ram_mem [DEPTH];
    always @(posedge clk) begin
        if (ram_en && ram_we) ram_mem[ram_addr] <= ram_din;
        ram_dout <= (ram_en && !ram_we) ? ram_mem[ram_addr] : '0;
    end

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           exp_wr[$];
    logic [DW-1:0] exp_rd[$];
    logic [DW-1:0] model_mem [DEPTH];
    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int done_exp = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expectations whenever the DUT presents a transfer.
    always @(negedge clk) begin
        if (!sys_rst) begin
            wr_t w;
            if (done) done_seen++;
            if (rd_valid && rd_ready) begin
                if (exp_rd.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
                else check("rd_data", 32'(rd_data), 32'(exp_rd.pop_front()));
            end
            if (ram_en && ram_we) begin
                if (exp_wr.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
                else begin
                    w = exp_wr.pop_front();
                    check("wr_addr", 32'(ram_addr), 32'(w.a));
                    check("wr_din", 32'(ram_din), 32'(w.d));
                end
            end
            if (wr_ready) check("we_follows_valid", 32'(ram_we), 32'(wr_valid));
            if (!busy) check("idle_no_en", 32'(ram_en), 32'd0);
        end
    end

    task automatic send_cmd(input logic we, input int a, input int l);
        int n = 0;
        cmd_we    = we;
        cmd_addr  = AW'(a);
        cmd_len   = AW'(l);
        cmd_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            if (++n > 50) begin
                check("cmd_ready_timeout", 32'd0, 32'd1);
                break;
            end
        end
        step();
        cmd_valid = 1'b0;
    endtask

    // mode 0: valid held, 1: pattern 1,0,0,1,1, 2: random gaps
    task automatic wr_burst(input int a, input int l, input int mode,
                            input int base);
        logic [DW-1:0] d;
        int ad;
        int gaps;
        send_cmd(1'b1, a, l);
        for (int i = 0; i <= l; i++) begin
            gaps = (mode == 0) ? 0 : (mode == 1) ? ((i == 1) ? 2 : 0)
                                 : int'($urandom_range(0, 2));
            repeat (gaps) begin
                wr_valid = 1'b0;
                wr_data  = DW'($urandom);
                step();
            end
            d  = (base < 0) ? DW'($urandom) : DW'(base + i);
            ad = (a + i) % DEPTH;
            exp_wr.push_back('{a: AW'(ad), d: d});
            model_mem[ad] = d;
            wr_valid = 1'b1;
            wr_data  = d;
            step();
        end
        wr_valid = 1'b0;
        @(negedge clk);
        check("wr_done", 32'(done), 32'd1);
        check("wr_back_idle", 32'(cmd_ready), 32'd1);
        done_exp++;
        step();
    endtask

    // mode 0: ready held, 1: random ready, 2: ready low for 10 cycles
    task automatic rd_burst(input int a, input int l, input int mode);
        int cyc = 1;
        int issues = 0;
        int iss10 = 0;
        int fi = 0;
        int fv = 0;
        int dc = 0;
        send_cmd(1'b0, a, l);
        for (int i = 0; i <= l; i++) exp_rd.push_back(model_mem[(a + i) % DEPTH]);
        forever begin
            rd_ready = (mode == 0) ? 1'b1 :
                       (mode == 1) ? 1'($urandom_range(0, 1)) : (cyc > 10);
            @(negedge clk);
            if (ram_en && !ram_we) begin
                issues++;
                if (fi == 0) fi = cyc;
            end
            if (rd_valid && fv == 0) fv = cyc;
            if (cyc == 10) iss10 = issues;
            if (done) dc = cyc;
            step();
            if (dc != 0) break;
            if (cyc >= 300) begin
                check("rd_done_timeout", 32'd0, 32'd1);
                exp_rd.delete();
                break;
            end
            cyc++;
        end
        rd_ready = 1'b0;
        done_exp++;
        check("rd_issue_count", 32'(issues), 32'(l + 1));
        check("rd_first_latency", 32'(fv - fi), 32'd2);
        check("rd_all_popped", 32'(exp_rd.size()), 32'd0);
        if (mode == 0) check("rd_done_cycle", 32'(dc), 32'(l + 5));
        if (mode == 2) check("bp_issues", 32'(iss10), 32'd4);
    endtask

    initial begin
        int dbefore;
        sys_rst   = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rd_ready  = 1'b0;
        #12;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_ram_en", 32'(ram_en), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_din", 32'(ram_din), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        step();
        sys_rst = 1'b0;
        step();

        wr_burst(0, 15, 0, -1);
        wr_burst(2, 3, 0, 'hA0);
        rd_burst(2, 3, 0);
        wr_burst(14, 3, 0, -1);
        rd_burst(14, 3, 0);
        rd_burst(0, 15, 2);
        wr_burst(7, 2, 1, -1);
        rd_burst(7, 2, 1);

        // Abort a read with two words buffered.
        dbefore = done_seen;
        send_cmd(1'b0, 0, 15);
        rd_ready = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check("pre_rst_rd_valid", 32'(rd_valid), 32'd1);
        #2;
        sys_rst = 1'b1;
        #1;
        check("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_ram_en", 32'(ram_en), 32'd0);
        exp_rd.delete();
        @(posedge clk);
        #3;
        sys_rst = 1'b0;
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        rd_burst(5, 3, 0);
        check("no_done_on_abort", 32'(done_seen - dbefore), 32'd1);

        for (int k = 0; k < 12; k++) begin
            int a = int'($urandom_range(0, DEPTH - 1));
            int l = int'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 1) == 1) wr_burst(a, l, 2 * int'($urandom_range(0, 1)), -1);
            else rd_burst(a, l, int'($urandom_range(0, 1)));
        end

        step();
        check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        check("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
        check("done_pulses", 32'(done_seen), 32'(done_exp));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
